inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle datapath.
- Issues PC-sequential reads to a variable-latency instruction memory and buffers returned 19-bit instructions with their 12-bit PCs in a small prefetch queue.
- Presents instructions to the datapath over a valid/ready handshake.
- Accepts a redirect (branch, jump, call, return target) that flushes the queue and all in-flight fetches.

Parameters:
- PC_W, 12: fetch address width.
- INST_W, 19: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  PC_W  fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  INST_W  returned instruction.
- inst_valid  out  1  instruction available to datapath.
- inst_ready  in  1  datapath consumes instruction this cycle.
- inst_data  out  INST_W  instruction.
- inst_pc  out  PC_W  PC of inst_data.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  PC_W  new fetch address.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC, queue empty, state IDLE.
  - imem_req_valid=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0.
- Reset mid-transaction abandons any outstanding request; a response arriving after reset is ignored until a new request is issued.
- At most one outstanding memory request. FSM states:
  - IDLE: no request outstanding.
    - Assert imem_req_valid with imem_addr=fetch_pc when count < DEPTH and no redirect this cycle.
    - On req_valid && req_ready, go to WAIT and set fetch_pc=fetch_pc+1 (mod 2^PC_W; 0xFFF wraps to 0x000).
  - WAIT: request accepted, response pending.
    - On rsp_valid, push {pc, inst} into the queue; the pc is the one captured at acceptance. Go to IDLE.
    - Redirect while in WAIT goes to DRAIN.
  - DRAIN: response pending but stale.
    - On rsp_valid, discard the data and go to IDLE.
    - A further redirect in DRAIN stays in DRAIN and updates fetch_pc.
- Request stability:
  - imem_req_valid and imem_addr stay stable until accepted.
  - Exception: a redirect withdraws an unaccepted request (req_valid=0 that cycle). The memory protocol permits this.
- The rsp_valid slot is reserved in advance: no request is issued unless count < DEPTH, so a push never overflows.
- Output handshake:
  - inst_valid = queue non-empty.
  - inst_data and inst_pc come from the queue head.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect, cycle R:
  - Queue flushed (count=0); fetch_pc=redirect_pc.
  - No request issued in cycle R.
  - Redirect wins over a same-cycle pop, push or rsp_valid; the response is discarded and state goes to IDLE if the response landed in cycle R.
  - First request for redirect_pc is in cycle R+1 if the state is IDLE; otherwise after the drain completes.
- Latency: memory response in cycle N gives inst_valid at cycle N+1 (no bypass).
- Steady state with 1-cycle memory: one instruction every 2 cycles.
- A full queue stalls requests. A full queue with inst_ready=0 holds its outputs stable.

Optional Feature:
- Macro IFU_BYPASS_EN.
- Defined: when the queue is empty, state is WAIT, rsp_valid=1 and no redirect, the response drives inst_valid, inst_data and inst_pc combinationally in the same cycle.
  - If inst_ready=1 it is consumed without entering the queue.
  - Otherwise it is pushed as normal.
- Not defined: responses always enter the queue first, giving a 1-cycle minimum latency.

Decomposition:
- Package ifu_pkg holds:
  - PC_W and INST_W constants.
  - fetch_entry_t struct {pc, inst}.
  - fetch_state_t enum {IDLE, WAIT, DRAIN}.
- One sub-module, fetch_queue: a synchronous FIFO of fetch_entry_t with push, pop, flush, count, and flush priority over push and pop.

Test Plan:
- Reset release, 1-cycle memory returning inst = addr+0x100, inst_ready=1 → imem_addr sequence 0,1,2…; inst_pc 0,1,2 with inst_data 0x100,0x101,0x102; no gaps beyond 2-cycle cadence.
- inst_ready=0 for 20 cycles → exactly 4 entries queued (pcs 0–3), imem_req_valid=0 while full, outputs stable; releasing ready drains 0,1,2,3 in order.
- Redirect to 0x050 while in WAIT for addr 5, response arrives 3 cycles later → response dropped, next request addr 0x050, first inst_pc=0x050.
- Redirect in the same cycle as rsp_valid and inst_ready → queue empty next cycle, no pop counted, request 0x050 next cycle.
- fetch_pc reaches 0xFFF → next imem_addr 0x000; inst_pc shows 0xFFF then 0x000.
- Redirect while req_valid=1 and req_ready=0 → req_valid drops that cycle, then reasserts with redirect_pc; under IFU_BYPASS_EN the empty-queue response appears with inst_valid in the same cycle.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, queue entry layout and fetch FSM states for the instruction fetch unit.
package ifu_pkg;

  localparam int PC_W   = 12;
  localparam int INST_W = 19;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Synchronous FIFO of fetch entries; flush beats push and pop in the same cycle.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, prefetch queue, redirect flush.
// Define IFU_BYPASS_EN to forward a response straight to the datapath when the queue is empty.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head, rsp_entry;
  logic             q_empty, req_fire, rsp_live, bypass_hit, push, pop;

  assign q_empty        = (count == '0);
  assign imem_req_valid = reset && (state_q == IDLE) && (count != FULL) && !redirect_valid;
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_live       = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  assign rsp_entry      = '{pc: req_pc_q, inst: imem_rsp_data};

`ifdef IFU_BYPASS_EN
  assign bypass_hit = rsp_live && q_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    inst_valid = !q_empty;
    inst_pc    = '0;
    inst_data  = '0;
    if (!q_empty) begin
      inst_pc   = head.pc;
      inst_data = head.inst;
    end else if (bypass_hit) begin
      inst_valid = 1'b1;
      inst_pc    = rsp_entry.pc;
      inst_data  = rsp_entry.inst;
    end
  end

  assign pop  = !q_empty && inst_ready;
  assign push = rsp_live && !(bypass_hit && inst_ready);

  // A redirect always retargets fetch_pc; a response landing in the redirect cycle is dropped.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_W'(1);
        end
      end
      WAIT: begin
        if (imem_rsp_valid)      state_d = IDLE;
        else if (redirect_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (rsp_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

endmodule
